// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column strobing, row synchronisation, scan-level
// debouncing and one-hot digit / star / pound / multi-key decode.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [9:0] keypad_buttons,
    output logic       star,
    output logic       pound,
    output logic       new_key,
    output logic       multi_key
);

    localparam int unsigned ROWS  = 4;
    localparam int unsigned KEYS  = 12;
    localparam int unsigned DIGS  = 10;
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned STB_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STABLE_MAX = STB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROWS-1:0]   row_meta_q, row_sync_q;
    logic [KEYS-1:0]   snap_q, snap_d;
    logic [KEYS-1:0]   prev_q, prev_d;
    logic [KEYS-1:0]   commit_q, commit_d;
    logic [STB_W-1:0]  stable_q, stable_d;
    logic [2:0]        col_q, col_d;
    logic [DIGS-1:0]   buttons_q, buttons_d;
    logic              star_q, star_d;
    logic              pound_q, pound_d;
    logic              new_key_q, new_key_d;
    logic              multi_q, multi_d;

    logic [ROWS-1:0]   rows_act;
    logic              last;
    logic              single;

    // Scan sequencing, snapshot capture, debounce and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        snap_d    = snap_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        commit_d  = commit_q;
        col_d     = col_q;
        buttons_d = '0;
        star_d    = 1'b0;
        pound_d   = 1'b0;
        multi_d   = 1'b0;
        new_key_d = 1'b0;
        rows_act  = ~row_sync_q;
        last      = (cnt_q == DWELL_LAST);
        single    = 1'b0;

        if (last) begin
            cnt_d = '0;
        end

        case (state_q)
            COL0: if (last) begin
                snap_d[9] = rows_act[3];
                snap_d[6] = rows_act[2];
                snap_d[3] = rows_act[1];
                snap_d[0] = rows_act[0];
                state_d   = COL1;
            end
            COL1: if (last) begin
                snap_d[10] = rows_act[3];
                snap_d[7]  = rows_act[2];
                snap_d[4]  = rows_act[1];
                snap_d[1]  = rows_act[0];
                state_d    = COL2;
            end
            COL2: if (last) begin
                snap_d[11] = rows_act[3];
                snap_d[8]  = rows_act[2];
                snap_d[5]  = rows_act[1];
                snap_d[2]  = rows_act[0];
                state_d    = COL0;
                if (snap_d == prev_q) begin
                    if (stable_q != STABLE_MAX) begin
                        stable_d = stable_q + STB_W'(1);
                    end
                end else begin
                    stable_d = '0;
                end
                prev_d = snap_d;
            end
            default: begin
                state_d = COL0;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            COL1:    col_d = 3'b101;
            COL2:    col_d = 3'b011;
            default: col_d = 3'b110;
        endcase

        // prev_q holds the snapshot that just completed its stable run
        if (stable_q == STABLE_MAX) begin
            commit_d = prev_q;
        end

        single = (commit_d != '0) && ((commit_d & (commit_d - KEYS'(1))) == '0);
        if (single) begin
            buttons_d[0]   = commit_d[10];
            buttons_d[9:1] = commit_d[8:0];
            star_d         = commit_d[9];
            pound_d        = commit_d[11];
            new_key_d      = (commit_d != commit_q);
        end
        multi_d = (commit_d != '0) && !single;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= COL0;
            cnt_q      <= '0;
            row_meta_q <= '1;
            row_sync_q <= '1;
            snap_q     <= '0;
            prev_q     <= '0;
            commit_q   <= '0;
            stable_q   <= '0;
            col_q      <= 3'b110;
            buttons_q  <= '0;
            star_q     <= 1'b0;
            pound_q    <= 1'b0;
            new_key_q  <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
            snap_q     <= snap_d;
            prev_q     <= prev_d;
            commit_q   <= commit_d;
            stable_q   <= stable_d;
            col_q      <= col_d;
            buttons_q  <= buttons_d;
            star_q     <= star_d;
            pound_q    <= pound_d;
            new_key_q  <= new_key_d;
            multi_q    <= multi_d;
        end
    end

    assign col_out        = col_q;
    assign keypad_buttons = buttons_q;
    assign star           = star_q;
    assign pound          = pound_q;
    assign new_key        = new_key_q;
    assign multi_key      = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a passive keypad model drives the rows
// from the strobed columns; expectations come from a key-set decode model.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned LAT      = (DEB + 2) * 3 * SCAN_DIV + 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic [9:0]  keypad_buttons;
    logic        star, pound, new_key, multi_key;

    logic [11:0] pressed = '0;
    int          checks = 0;
    int          errors = 0;
    int          nk_total = 0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .row_in         (row_in),
        .col_out        (col_out),
        .keypad_buttons (keypad_buttons),
        .star           (star),
        .pound          (pound),
        .new_key        (new_key),
        .multi_key      (multi_key)
    );

    always #5 clk = ~clk;

    // Keypad: a held key at (r,c) pulls row r low while column c is strobed low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((|(pressed & (12'd1 << (3 * r + c)))) && !(|(col_out & (3'd1 << c))))
                    row_in = row_in & ~(4'd1 << r);
            end
        end
    end

    always @(negedge clk) if (new_key === 1'b1) nk_total <= nk_total + 1;

    // Packed {multi, pound, star, buttons[9:0]}
    function automatic logic [12:0] obs();
        obs = {multi_key, pound, star, keypad_buttons};
    endfunction

    // Key index 3r+c -> label: 0..8 are digits 1..9, 9 is '*', 10 is '0', 11 is '#'
    function automatic logic [12:0] model(input logic [11:0] keys);
        int n;
        int pos;
        logic [12:0] res;
        n   = $countones(keys);
        res = '0;
        if (n >= 2) begin
            res = 13'h1000;
        end else if (n == 1) begin
            for (int k = 0; k < 12; k++) begin
                if (|(keys & (12'd1 << k))) begin
                    if (k < 9)       pos = k + 1;
                    else if (k == 9) pos = 10;
                    else if (k == 10) pos = 0;
                    else             pos = 11;
                    res = 13'd1 << pos;
                end
            end
        end
        return res;
    endfunction

    task automatic wait_out(input logic [12:0] exp, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < int'(LAT); i++) begin
            @(negedge clk);
            if (obs() === exp) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic hold_out(input logic [12:0] exp, input int n, output bit stable);
        stable = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (obs() !== exp) stable = 1'b0;
        end
    endtask

    // Change the held keys, then measure settling, stability and strobe count
    task automatic apply(input logic [11:0] k, input logic [12:0] exp, input int hold,
                         output bit ok, output bit stable, output int pulses);
        int nk0;
        nk0     = nk_total;
        pressed = k;
        wait_out(exp, ok);
        hold_out(exp, hold, stable);
        pulses = nk_total - nk0;
    endtask

    task automatic test_reset();
        logic [2:0] exp_col;
        bit quiet;
        reset_n = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (col_out !== 3'b110) begin
            errors++; $display("FAIL reset_col: got %b want 110", col_out);
        end
        checks++;
        if (obs() !== 13'h0 || new_key !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got %h nk %b want 0", obs(), new_key);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            exp_col = ~(3'd1 << ((k / int'(SCAN_DIV)) % 3));
            checks++;
            if (col_out !== exp_col) begin
                errors++; $display("FAIL col_rotation[%0d]: got %b want %b", k, col_out, exp_col);
            end
        end
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (obs() !== 13'h0 || new_key !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL idle_quiet: got %h want 0", obs());
        end
    endtask

    task automatic test_key5();
        bit ok, st; int p;
        apply(12'h010, 13'h020, 100, ok, st, p);
        checks++;
        if (!ok || !st) begin
            errors++; $display("FAIL key5_press: got %h want 020 (ok %0b stable %0b)", obs(), ok, st);
        end
        checks++;
        if (p != 1) begin
            errors++; $display("FAIL key5_pulses: got %0d want 1", p);
        end
        apply(12'h000, 13'h000, 30, ok, st, p);
        checks++;
        if (!ok || !st || p != 0) begin
            errors++; $display("FAIL key5_release: got %h pulses %0d want 000 pulses 0", obs(), p);
        end
    endtask

    task automatic test_sequence();
        logic [11:0] keys [4];
        logic [12:0] exps [4];
        bit ok, st; int p;
        keys = '{12'h400, 12'h200, 12'h800, 12'h100};
        exps = '{13'h0001, 13'h0400, 13'h0800, 13'h0200};
        for (int i = 0; i < 4; i++) begin
            apply(keys[i], exps[i], 30, ok, st, p);
            checks++;
            if (!ok || !st || p != 1) begin
                errors++; $display("FAIL seq_press[%0d]: got %h pulses %0d want %h pulses 1", i, obs(), p, exps[i]);
            end
            apply(12'h000, 13'h000, 20, ok, st, p);
            checks++;
            if (!ok || !st || p != 0) begin
                errors++; $display("FAIL seq_release[%0d]: got %h pulses %0d want 0 pulses 0", i, obs(), p);
            end
        end
    endtask

    task automatic test_bounce();
        bit quiet, ok, st; int p, nk0;
        nk0   = nk_total;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 12'h004 : 12'h000;
            repeat (5) begin
                @(negedge clk);
                if (obs() !== 13'h0 || new_key !== 1'b0) quiet = 1'b0;
            end
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL bounce_quiet: got %h want 0", obs());
        end
        apply(12'h004, 13'h008, 40, ok, st, p);
        checks++;
        if (!ok || !st || (nk_total - nk0) != 1) begin
            errors++; $display("FAIL bounce_commit: got %h pulses %0d want 008 pulses 1", obs(), nk_total - nk0);
        end
        apply(12'h000, 13'h000, 20, ok, st, p);
    endtask

    task automatic test_multi();
        bit ok, st; int p;
        apply(12'h003, 13'h1000, 30, ok, st, p);
        checks++;
        if (!ok || !st || p != 0) begin
            errors++; $display("FAIL multi_hold: got %h pulses %0d want 1000 pulses 0", obs(), p);
        end
        apply(12'h001, 13'h0002, 30, ok, st, p);
        checks++;
        if (!ok || !st || p != 1) begin
            errors++; $display("FAIL multi_to_one: got %h pulses %0d want 0002 pulses 1", obs(), p);
        end
        apply(12'h000, 13'h000, 20, ok, st, p);
    endtask

    task automatic test_reset_midpress();
        bit ok, st; int p;
        apply(12'h040, 13'h080, 20, ok, st, p);
        checks++;
        if (!ok || p != 1) begin
            errors++; $display("FAIL key7_commit: got %h pulses %0d want 080 pulses 1", obs(), p);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 13'h0 || new_key !== 1'b0 || col_out !== 3'b110) begin
            errors++; $display("FAIL async_reset: got %h col %b want 0 col 110", obs(), col_out);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        apply(12'h040, 13'h080, 20, ok, st, p);
        checks++;
        if (!ok || !st || p != 1) begin
            errors++; $display("FAIL key7_after_reset: got %h pulses %0d want 080 pulses 1", obs(), p);
        end
        apply(12'h000, 13'h000, 20, ok, st, p);
    endtask

    task automatic test_random();
        logic [11:0] k, prev;
        logic [12:0] exp;
        int n, exp_p, p;
        bit ok, st;
        prev = '0;
        for (int it = 0; it < 12; it++) begin
            n = int'($urandom_range(0, 2));
            k = '0;
            while ($countones(k) < n) k = k | (12'd1 << $urandom_range(0, 11));
            exp   = model(k);
            exp_p = ($countones(k) == 1 && k != prev) ? 1 : 0;
            apply(k, exp, 30, ok, st, p);
            checks++;
            if (!ok || !st || p != exp_p) begin
                errors++;
                $display("FAIL random[%0d] keys %h: got %h pulses %0d want %h pulses %0d", it, k, obs(), p, exp, exp_p);
            end
            prev = k;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_key5();
        test_sequence();
        test_bounce();
        test_multi();
        test_reset_midpress();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4-row x 3-column phone-style matrix keypad and turns it into the 10-bit one-hot `keypad_buttons` bus consumed by the alarm-clock keypad digit-entry block.
- Also reports `*` and `#`, a one-cycle new-key strobe, and a multi-key error flag.
- Handles column strobing, row synchronisation and debouncing, so downstream logic sees clean, glitch-free key levels.

Parameters:
- SCAN_DIV, 4: clocks each column is driven before its rows are sampled; legal minimum 3.
- DEBOUNCE_SCANS, 3: consecutive full scans whose 12-key snapshot must equal the previous snapshot before it is committed; legal minimum 1.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- row_in  input  4  keypad rows, active-low (pulled up externally); asynchronous to clk.
- col_out  output  4→3  see below: 3 bits, column strobes, active-low, exactly one bit low at any time.
- keypad_buttons  output  10  debounced one-hot digit; bit n = digit n held.
- star  output  1  debounced `*` held.
- pound  output  1  debounced `#` held.
- new_key  output  1  one-cycle pulse when a single key becomes committed.
- multi_key  output  1  committed snapshot has two or more keys pressed.

(col_out width is 3.)

Behaviour:
- **Key map** (row r, column c): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#. Snapshot bit index = 3r+c.
- **Reset (async, reset_n=0)**:
  - col_out=3'b110 and FSM in COL0.
  - Dwell counter, stable counter, snapshot, previous snapshot and committed vector all cleared.
  - Every output is 0.
  - Deasserting reset in the middle of a press restarts debouncing from scratch; nothing stale is emitted.
- **Row synchroniser**: row_in goes through a two-flop synchroniser, then is inverted to active-high.
- **FSM states COL0 → COL1 → COL2 → COL0**:
  - col_out is 110, 101 and 011 respectively.
  - Each state lasts exactly SCAN_DIV clocks, so one full scan = 3*SCAN_DIV clocks.
  - On the last clock of each state, the synchronised rows are written into snapshot bits {9+c, 6+c, 3+c, c}.
  - Only after that write does the FSM advance to the next column.
- **End of scan** (the last clock of COL2, after the write):
  - If the snapshot equals the previous snapshot, the stable counter increments, saturating at DEBOUNCE_SCANS. Otherwise the stable counter is set to 0.
  - The previous snapshot is updated to the snapshot.
  - When the stable counter reaches DEBOUNCE_SCANS, the snapshot is copied to the committed vector on the next clock. It stays committed until a different snapshot has itself been stable for DEBOUNCE_SCANS scans.
- **Registered outputs, derived from the committed vector**:
  - Exactly one bit set: the matching keypad_buttons bit, star or pound is 1; multi_key=0.
  - Zero bits set: all outputs 0.
  - Two or more bits set: multi_key=1; keypad_buttons, star and pound are all 0. Ghost keys are treated the same way.
- **new_key**:
  - Pulses high for one clock when the committed vector changes to a single-key value different from the prior committed value. This covers zero→key, multi→key and keyA→keyB.
  - It never pulses on release, and never pulses while a key is held.
- **Latency**: a change on row_in that is held steady is reflected on the outputs within (DEBOUNCE_SCANS+2)*3*SCAN_DIV+4 clocks. With the defaults that bound is 64 clocks.
- **Glitch filtering**: any row_in glitch shorter than DEBOUNCE_SCANS full scans never reaches the outputs.
- **Stability**: the committed outputs are levels and hold steady while the key is held. The consuming block does its own edge detection.

Test Plan:
- Reset held, then released with no key pressed:
  - During reset: col_out=110 and all outputs 0.
  - After release: col_out rotates 110→101→011 at 4 clocks per step.
  - Outputs stay 0 for 200 clocks.
- Key 5 (row1 low whenever col1 is strobed) held for 150 clocks:
  - Within 64 clocks, keypad_buttons=10'h020 and new_key pulses exactly once.
  - On release, keypad_buttons returns to 10'h000 within 64 clocks, with no new_key pulse.
- Sequence 0, *, #, 9 pressed and released in turn:
  - keypad_buttons=10'h001 with one new_key pulse.
  - star=1 with one new_key pulse.
  - pound=1 with one new_key pulse.
  - keypad_buttons=10'h200 with one new_key pulse.
- Key 3 bouncing (toggling every 5 clocks for 30 clocks) then held:
  - No output activity during the bounce.
  - Then exactly one committed 10'h008 with a single new_key pulse.
- Keys 1 and 2 held together:
  - multi_key=1 and keypad_buttons=0, with no new_key pulse.
  - Releasing key 2 gives keypad_buttons=10'h002, multi_key=0 and one new_key pulse.
- Key 7 committed, then reset_n pulsed low for 3 clocks while 7 stays held:
  - All outputs go to 0 immediately (asynchronously).
  - After reset is released, 10'h080 returns within 64 clocks with a new_key pulse.
